// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline stages.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  // sll $0,$0,0 -- the architectural no-op used for bubbles
  localparam logic [WORD_W-1:0] MIPS_NOP = 32'h0000_0000;

  localparam logic [WORD_W-1:0] MIPS_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds instruction, PC+4 and a valid bit.
// A flush loads a bubble (NOP, valid=0) while still recording pc4.
// Also serves as the template for the ID/EX register.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = MIPS_NOP
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc4_i,
  input  logic              valid_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc4_o,
  output logic              valid_o
);

  logic [WORD_W-1:0] instr_q, pc4_q;
  logic              valid_q;

  // Register update: reset to bubble, hold when not loading, flush inserts NOP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc4_q <= pc4_i;
      if (flush_i) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else begin
        instr_q <= instr_i;
        valid_q <= valid_i;
      end
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, +4 adder, next-PC priority
// (stall > redirect > sequential) and the IF/ID register.
// Optional macro DELAY_SLOT_EN: when defined, the instruction fetched
// alongside a taken redirect is kept (MIPS delay slot) instead of flushed.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = MIPS_RESET_PC,
  parameter logic [WORD_W-1:0] NOP_INSTR = MIPS_NOP
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic [WORD_W-1:0] imem_instr_i,
  output logic [WORD_W-1:0] id_instr_o,
  output logic [WORD_W-1:0] id_pc4_o,
  output logic              id_valid_o
);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] redirect_target;
  logic              flush;

  assign pc_plus4 = pc_q + WORD_W'(4);
  // Low two bits of the target are dropped silently; no alignment trap
  assign redirect_target = redirect_pc_i & ~WORD_W'(3);

  // Next-PC selection; a stalled branch's redirect is not yet final
  always_comb begin
    pc_d = pc_plus4;
    if (stall_i) begin
      pc_d = pc_q;
    end else if (redirect_i) begin
      pc_d = redirect_target;
    end
  end

  // PC register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef DELAY_SLOT_EN
  assign flush = 1'b0;
`else
  assign flush = redirect_i;
`endif

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (~stall_i),
    .flush_i (flush),
    .instr_i (imem_instr_i),
    .pc4_i   (pc_plus4),
    .valid_i (1'b1),
    .instr_o (id_instr_o),
    .pc4_o   (id_pc4_o),
    .valid_o (id_valid_o)
  );

  assign imem_addr_o = pc_q;

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Front end of the 5-stage MIPS pipeline: owns the program counter, drives the word-addressed instruction memory, and registers the fetched instruction into the IF/ID pipeline register. Handles sequential fetch, hazard-unit stalls and branch/jump redirects resolved in ID. Feeds the decode stage. The instruction memory is combinational and external to this block.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on flush/reset (sll $0,$0,0)

Ports:
- clk_i  input  1  sole clock; all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- stall_i  input  1  hazard unit: hold PC and IF/ID contents
- redirect_i  input  1  ID-stage branch taken or jump; load redirect_pc_i
- redirect_pc_i  input  32  redirect target byte address
- imem_addr_o  output  32  byte address to instruction memory
- imem_instr_i  input  32  instruction returned combinationally for imem_addr_o
- id_instr_o  output  32  registered instruction to ID
- id_pc4_o  output  32  registered PC+4 of that instruction
- id_valid_o  output  1  1 = id_instr_o is a real instruction, 0 = bubble

## Operation

- PC register drives imem_addr_o directly; pc_plus4 = PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Each edge, exactly one case applies, in priority order:
  - rst_i: PC = RESET_PC; id_instr_o = NOP_INSTR; id_pc4_o = 0; id_valid_o = 0.
  - stall_i = 1: PC, id_instr_o, id_pc4_o, id_valid_o all hold. redirect_i is ignored (the branch in ID is itself stalled, so its outcome is not final).
  - redirect_i = 1: PC = {redirect_pc_i[31:2], 2'b00}; IF/ID handling per Configuration.
  - Otherwise: PC = pc_plus4; id_instr_o = imem_instr_i; id_pc4_o = pc_plus4; id_valid_o = 1.
- Redirect target bits [1:0] are silently cleared; no misalignment trap.
- Reset can assert at any time, including mid-stall or mid-redirect. All state returns to reset values immediately, with no clock needed.

## Timing

- imem_addr_o follows the PC register with zero cycles of combinational delay. Instruction memory read is in the same cycle.
- Fetch-to-ID latency: 1 cycle.
- Redirect: taking effect at edge N puts the target on imem_addr_o after edge N. The target instruction appears on id_instr_o after edge N+1.
- First edge after reset release captures memory[RESET_PC>>2] with id_valid_o = 1, provided stall_i and redirect_i are both 0.
- Stall can last any number of cycles. Outputs are stable for the whole stall.

## Configuration

- DELAY_SLOT_EN defined (MIPS architectural delay slot):
  - On redirect, IF/ID captures imem_instr_i and pc_plus4 normally, with id_valid_o = 1.
  - The instruction after the branch executes.
- Not defined (flush):
  - On redirect, id_instr_o = NOP_INSTR, id_pc4_o = pc_plus4, id_valid_o = 0.
  - This costs one bubble per taken branch.

## Structure

- Shared package/header mips_pkg holds:
  - NOP_INSTR encoding
  - default RESET_PC
  - the 32-bit word width constant used by all pipeline stages
- Sub-module if_id_reg contains the IF/ID register:
  - inputs: instr/pc4/valid, plus load and flush enables
  - async reset to bubble values
  - reused as the template for the ID/EX register
- Top-level if_fetch_stage contains the PC register, the +4 adder and the next-PC priority logic.

## Test plan

- Reset with RESET_PC = 0, memory[0..2] = 0x20080001, 0x20090002, 0x01095020; release, 3 edges -> imem_addr_o 0, 4, 8, 0xC; id_instr_o sequence 0x20080001, 0x20090002, 0x01095020; id_pc4_o 4, 8, 0xC; id_valid_o = 1.
- stall_i high for 3 cycles at PC = 8 -> imem_addr_o stays 8 and id_instr_o/id_pc4_o/id_valid_o unchanged; fetch resumes at 0xC.
- redirect_i with target 0x40 at PC = 0x10 -> next imem_addr_o = 0x40. Without DELAY_SLOT_EN, id_valid_o = 0 and id_instr_o = NOP_INSTR. With DELAY_SLOT_EN, id_instr_o = memory[4] and id_valid_o = 1.
- redirect_i and stall_i both high -> no state change; redirect_pc_i = 0x43 alone -> PC = 0x40.
- PC = 0xFFFF_FFFC, no stall -> PC wraps to 0x0000_0000 and id_pc4_o = 0.
- rst_i pulsed asynchronously mid-stall, between edges -> outputs go to reset values immediately: imem_addr_o = RESET_PC, id_valid_o = 0.
